station_dispatch: RTL and testbench
===================================

# station_dispatch

Consumes station IDs from the barcode reader and drive commands from the UART command path, and decides when the line follower moves and stops. Latches a destination station from a "go" command, enables motion while `OK2Move` is high, stops when a valid barcode matching the destination is read, and sounds a piezo buzzer while motion is blocked by an obstacle. Sits between the barcode reader / command receiver and the motor controller.

## Interface
- `BUZZ_DIV`, 6250: clock cycles per buzzer half-period (4 kHz at 50 MHz).
- `TIMEOUT_W`, 26: width of the transit watchdog counter; used only with `STATION_TIMEOUT_EN`.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd` in 16: command word; `[15:14]` opcode, `[5:0]` destination station.
- `cmd_rdy` in 1: `cmd` is valid; level held until cleared.
- `clr_cmd_rdy` out 1: one-cycle pulse acknowledging `cmd`.
- `ID` in 8: station ID from the barcode reader; valid only when `ID[7:6]==2'b00`.
- `ID_vld` in 1: `ID` is valid; level held until cleared.
- `clr_ID_vld` out 1: one-cycle pulse acknowledging `ID`.
- `OK2Move` in 1: high when the path ahead is clear.
- `go` out 1: motion enable to the motor controller.
- `in_transit` out 1: a destination is latched and not yet reached.
- `buzz`, `buzz_n` out 1 each: complementary piezo drive.
- `timeout` out 1: one-cycle pulse on watchdog abort; constant 0 without the macro.

## Operation
- Opcodes: `2'b01` go to `cmd[5:0]`; `2'b00` stop; `2'b10`/`2'b11` ignored but still acknowledged.
- States: IDLE, MOVING. `in_transit` is 1 exactly in MOVING.
- IDLE, `cmd_rdy`: assert `clr_cmd_rdy`. On go, load `dest_ID <= cmd[5:0]` and move to MOVING. Otherwise stay.
- IDLE, `ID_vld`: assert `clr_ID_vld` and discard the ID.
- MOVING, `cmd_rdy`: assert `clr_cmd_rdy`.
  - Go: reload `dest_ID` and stay in MOVING.
  - Stop: move to IDLE.
  - Other opcodes: no change.
- MOVING, `ID_vld` with no `cmd_rdy` in the same cycle: assert `clr_ID_vld`.
  - If `ID[7:6]==2'b00` and `ID[5:0]==dest_ID`: move to IDLE.
  - Otherwise: stay in MOVING.
- Simultaneous `cmd_rdy` and `ID_vld`: the command wins. `ID_vld` is left pending and serviced next cycle against the updated `dest_ID`. In IDLE, both are acknowledged in the same cycle.
- `go = in_transit & OK2Move` (combinational).
- Buzzer:
  - While `in_transit & ~OK2Move`, a counter runs 0..`BUZZ_DIV`-1. `buzz` toggles on wrap and `buzz_n = ~buzz`.
  - Otherwise the counter is held at 0, `buzz`=0 and `buzz_n`=1.

## Timing
- Reset values:
  - state IDLE, `dest_ID`=0, `in_transit`=0, `go`=0.
  - `buzz`=0, `buzz_n`=1, `timeout`=0, `clr_cmd_rdy`=0, `clr_ID_vld`=0.
- `clr_cmd_rdy` and `clr_ID_vld` are combinational from state and inputs. They are high in the same cycle the request is first seen, for exactly one cycle, provided upstream drops its flag on the following edge.
- `in_transit` and `dest_ID` update on the clock edge ending the acknowledge cycle. `go` follows one cycle after `cmd_rdy` is sampled.
- First `buzz` toggle occurs `BUZZ_DIV` cycles after obstruction begins. When `OK2Move` rises, `buzz` returns to 0 on the next edge.
- A reset mid-transit aborts immediately: `go` drops asynchronously with `rst_n`.

## Configuration
- `STATION_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit watchdog clears on entry to MOVING and on every serviced `ID_vld`. It counts while in MOVING.
  - When all ones, go to IDLE and pulse `timeout` for one cycle.
  - The watchdog holds while `~OK2Move`.
- Not defined: no watchdog logic; `timeout` is tied to 0. MOVING persists until a matching ID or a stop command arrives.

## Test plan
- Reset, then `cmd=16'h4015`, `cmd_rdy` → `clr_cmd_rdy` pulses 1 cycle; next cycle `in_transit`=1 and `go`=1 with `OK2Move`=1.
- While moving to 0x15: `ID=8'h07` then `ID=8'h15` → both acknowledged; stays MOVING after 0x07; `in_transit`=0 and `go`=0 after 0x15.
- Moving to 0x15, `ID=8'h55` (bits [7:6]=01) → acknowledged, ignored, still MOVING.
- `OK2Move`=0 for 3×`BUZZ_DIV` cycles → `go`=0; `buzz` toggles 3 times with `buzz_n` complementary; `OK2Move`=1 → `buzz`=0 next edge.
- Moving to 0x15: `cmd=16'h4009` and `ID=8'h09` asserted in the same cycle → cmd acked first, ID acked next cycle, block ends in IDLE. Separately, `cmd=16'h0000` while moving → IDLE.
- With `STATION_TIMEOUT_EN`, `TIMEOUT_W`=4: go command, no IDs → `timeout` pulses after 15 MOVING cycles; `in_transit`=0.

Source files
------------

// File: rtl/station_dispatch.sv
// station_dispatch: latches a destination from go commands, gates motion until the matching station ID, buzzes while blocked.
// Optional transit watchdog enabled by defining STATION_TIMEOUT_EN.
module station_dispatch #(
  parameter int BUZZ_DIV  = 6250,
  parameter int TIMEOUT_W = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic [7:0]  ID,
  input  logic        ID_vld,
  output logic        clr_ID_vld,
  input  logic        OK2Move,
  output logic        go,
  output logic        in_transit,
  output logic        buzz,
  output logic        buzz_n,
  output logic        timeout
);
  localparam int CW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  typedef enum logic {IDLE, MOVING} state_t;
  state_t state_q, state_d;
  logic [5:0]    dest_id_q, dest_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          buzz_q, buzz_d;
  logic [1:0]    op;
  logic          blocked, wrap;
  logic          unused_cmd;
  assign op         = cmd[15:14];
  assign unused_cmd = ^cmd[13:6];
  assign blocked    = in_transit & ~OK2Move;
  assign wrap       = cnt_q == CW'(BUZZ_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      dest_id_q <= '0;
      cnt_q     <= '0;
      buzz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_id_q <= dest_id_d;
      cnt_q     <= cnt_d;
      buzz_q    <= buzz_d;
    end
  // A pending command always shadows a pending ID while moving.
  always_comb begin
    state_d   = state_q;
    dest_id_d = dest_id_q;
    if (state_q == IDLE) begin
      if (cmd_rdy && op == 2'b01) begin
        state_d   = MOVING;
        dest_id_d = cmd[5:0];
      end
    end else if (cmd_rdy) begin
      if (op == 2'b01) dest_id_d = cmd[5:0];
      else if (op == 2'b00) state_d = IDLE;
    end else if (ID_vld && ID[7:6] == 2'b00 && ID[5:0] == dest_id_q) begin
      state_d = IDLE;
    end
    if (timeout) state_d = IDLE;
  end
  always_comb begin
    cnt_d  = blocked ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    buzz_d = blocked ? buzz_q ^ wrap : 1'b0;
  end
  always_comb begin
    in_transit  = state_q == MOVING;
    go          = in_transit & OK2Move;
    clr_cmd_rdy = cmd_rdy;
    clr_ID_vld  = ID_vld & (~in_transit | ~cmd_rdy);
    buzz        = buzz_q;
    buzz_n      = ~buzz_q;
  end
`ifdef STATION_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  // Held at zero in IDLE so entry to MOVING starts from a clean count.
  always_comb wd_d = (!in_transit || (ID_vld && !cmd_rdy)) ? '0 : (OK2Move ? wd_q + 1'b1 : wd_q);
  assign timeout = in_transit & (&wd_q);
`else
  logic unused_w;
  assign unused_w = TIMEOUT_W > 0;
  assign timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_station_dispatch.sv
// tb_station_dispatch: directed vectors with hand-computed expectations for station_dispatch.
module tb_station_dispatch;
  localparam int BD = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic cmd_rdy = 1'b0, ID_vld = 1'b0, OK2Move = 1'b0;
  logic [7:0] ID = '0;
  logic clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n, timeout;
  int total = 0, bad = 0;
  station_dispatch #(.BUZZ_DIV(BD), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
    .go(go), .in_transit(in_transit), .buzz(buzz), .buzz_n(buzz_n), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic [15:0] c);
    cmd = c;
    cmd_rdy = 1'b1;
    #1 chk("clr_cmd_hi", clr_cmd_rdy, 1);
    tick();
    cmd_rdy = 1'b0;
    #1 chk("clr_cmd_lo", clr_cmd_rdy, 0);
  endtask
  task automatic send_id(input logic [7:0] i);
    ID = i;
    ID_vld = 1'b1;
    #1 chk("clr_id_hi", clr_ID_vld, 1);
    tick();
    ID_vld = 1'b0;
    #1;
  endtask
  initial begin
    int toggles, seen;
    logic prev;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_go", go, 0);
    chk("rst_transit", in_transit, 0);
    chk("rst_buzz", buzz, 0);
    chk("rst_buzz_n", buzz_n, 1);
    chk("rst_timeout", timeout, 0);
    chk("rst_clr_cmd", clr_cmd_rdy, 0);
    chk("rst_clr_id", clr_ID_vld, 0);
    rst_n = 1'b1;
    OK2Move = 1'b1;
    tick();
    send_cmd(16'h4015);
    chk("go15_transit", in_transit, 1);
    chk("go15_go", go, 1);
    send_id(8'h07);
    chk("id07_stay", in_transit, 1);
    send_id(8'h15);
    chk("id15_arrive", in_transit, 0);
    chk("id15_go", go, 0);
    send_id(8'h15);
    chk("idle_id_discard", in_transit, 0);
    send_cmd(16'h8015);
    chk("idle_op2_ignored", in_transit, 0);
    send_cmd(16'h4015);
    send_id(8'h55);
    chk("id55_ignored", in_transit, 1);
    OK2Move = 1'b0;
    #1 chk("blocked_go", go, 0);
    chk("blocked_buzz0", buzz, 0);
    toggles = 0;
    prev = buzz;
    for (int n = 1; n <= 3 * BD; n++) begin
      tick();
      if (buzz !== prev) toggles++;
      prev = buzz;
      if (n == BD - 1) chk("buzz_pre_first", buzz, 0);
      if (n == BD) chk("buzz_first", buzz, 1);
      if (n == 2 * BD) chk("buzz_second", buzz, 0);
      if (n == 3 * BD) begin
        chk("buzz_third", buzz, 1);
        chk("buzz_n_third", buzz_n, 0);
      end
    end
    chk("buzz_toggles", toggles, 3);
    OK2Move = 1'b1;
    #1 chk("unblock_go", go, 1);
    tick();
    chk("unblock_buzz", buzz, 0);
    chk("unblock_buzz_n", buzz_n, 1);
    cmd = 16'h4009;
    cmd_rdy = 1'b1;
    ID = 8'h09;
    ID_vld = 1'b1;
    #1 chk("both_cmd_ack", clr_cmd_rdy, 1);
    chk("both_id_held", clr_ID_vld, 0);
    tick();
    cmd_rdy = 1'b0;
    #1 chk("both_id_ack", clr_ID_vld, 1);
    chk("both_cmd_done", clr_cmd_rdy, 0);
    chk("both_mid_transit", in_transit, 1);
    tick();
    ID_vld = 1'b0;
    #1 chk("both_arrive", in_transit, 0);
    send_cmd(16'h4015);
    send_cmd(16'hC000);
    chk("mov_op3_ignored", in_transit, 1);
    send_cmd(16'h0000);
    chk("stop_cmd", in_transit, 0);
    cmd = 16'h4020;
    cmd_rdy = 1'b1;
    ID = 8'h20;
    ID_vld = 1'b1;
    #1 chk("idle_both_cmd", clr_cmd_rdy, 1);
    chk("idle_both_id", clr_ID_vld, 1);
    tick();
    cmd_rdy = 1'b0;
    ID_vld = 1'b0;
    #1 chk("idle_both_move", in_transit, 1);
    seen = 0;
`ifdef STATION_TIMEOUT_EN
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (timeout) begin
        seen = n;
        break;
      end
    end
    chk("wd_cycles", seen, 15);
    chk("wd_pulse_transit", in_transit, 1);
    tick();
    chk("wd_idle", in_transit, 0);
    chk("wd_pulse_end", timeout, 0);
    send_cmd(16'h4021);
`else
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (timeout) seen++;
    end
    chk("no_wd_timeout", seen, 0);
`endif
    chk("pre_rst_go", go, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_go", go, 0);
    chk("async_rst_transit", in_transit, 0);
    tick();
    rst_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
